// File: rtl/trigger_pkg.sv
// Shared types for the trigger configuration bus: the write-beat payload and the
// arbiter FSM states.
package trigger_pkg;

  localparam int TRG_BAW = 8;
  localparam int TRG_BDW = 32;
  localparam int TRG_BSW = 4;

  typedef struct packed {
    logic [TRG_BAW-1:0] addr;
    logic [TRG_BDW-1:0] data;
    logic [TRG_BSW-1:0] selct;
  } t_bus_beat;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } t_arb_state;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request scanning
// ptr, ptr+1, ... modulo RN.
module arb_rr_pick #(
  parameter int  RN  = 4,
  localparam int RIW = $clog2(RN)
) (
  input  logic [RN-1:0]  req_i,
  input  logic [RIW-1:0] ptr_i,
  output logic           any_o,
  output logic [RIW-1:0] idx_o
);

  // Scan from the far end back toward ptr so the last hit is the nearest one.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = RN - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % RN]) begin
        any_o = 1'b1;
        idx_o = RIW'((int'(ptr_i) + k) % RN);
      end else begin
        any_o = any_o;
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/trigger_bus_arbiter.sv
// Round-robin arbiter sharing the trigger configuration write bus between RN
// requesters, with an owner lock for multi-beat sequences and a registered output.
module trigger_bus_arbiter
  import trigger_pkg::*;
#(
  parameter int  BAW = TRG_BAW,
  parameter int  BDW = TRG_BDW,
  parameter int  BSW = TRG_BSW,
  parameter int  RN  = 4,
  localparam int RIW = $clog2(RN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RN-1:0]     req_wvalid,
  output logic [RN-1:0]     req_wready,
  input  logic [RN*BAW-1:0] req_waddr,
  input  logic [RN*BDW-1:0] req_wdata,
  input  logic [RN*BSW-1:0] req_wselct,
  input  logic [RN-1:0]     req_wlock,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic [BAW-1:0]    bus_waddr,
  output logic [BDW-1:0]    bus_wdata,
  output logic [BSW-1:0]    bus_wselct,
  output logic              gnt_vld,
  output logic [RIW-1:0]    gnt_id
);

  t_arb_state     state_q, state_d;
  logic [RIW-1:0] ptr_q, ptr_d;
  logic [RIW-1:0] own_q, own_d;
  t_bus_beat      beat_q, beat_d;
  logic           bvalid_q, bvalid_d;
  logic [RN-1:0]  pick_req_s;
  logic           pick_any_s;
  logic [RIW-1:0] pick_idx_s;
  logic           owning_s, own_rdy_s, xfer_s, release_s;

  assign pick_req_s = req_wvalid | req_wlock;

  arb_rr_pick #(.RN(RN)) u_pick (
    .req_i (pick_req_s),
    .ptr_i (ptr_q),
    .any_o (pick_any_s),
    .idx_o (pick_idx_s)
  );

  assign owning_s  = (state_q == OWN);
  assign own_rdy_s = owning_s & (~bvalid_q | bus_wready);
  assign xfer_s    = own_rdy_s & req_wvalid[own_q];
  // A locked owner keeps the bus even through gaps; otherwise it lets go after a beat or when quiet.
  assign release_s = owning_s & ~req_wlock[own_q] & (xfer_s | ~req_wvalid[own_q]);

  // Only the current owner ever sees ready.
  always_comb begin
    req_wready = '0;
    if (owning_s) begin
      req_wready[own_q] = ~bvalid_q | bus_wready;
    end else begin
      req_wready = '0;
    end
  end

  // Ownership FSM and round-robin pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = OWN;
          own_d   = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (release_s) begin
          state_d = IDLE;
          ptr_d   = (own_q == RIW'(RN - 1)) ? '0 : own_q + RIW'(1);
        end else begin
          state_d = OWN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: load on a transfer, drain when the bus accepts, hold while stalled.
  always_comb begin
    beat_d   = beat_q;
    bvalid_d = bvalid_q;
    if (xfer_s) begin
      beat_d.addr  = req_waddr[int'(own_q) * BAW +: BAW];
      beat_d.data  = req_wdata[int'(own_q) * BDW +: BDW];
      beat_d.selct = req_wselct[int'(own_q) * BSW +: BSW];
      bvalid_d     = 1'b1;
    end else if (bus_wready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // State registers; reset discards any buffered beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      own_q    <= '0;
      beat_q   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      beat_q   <= beat_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign bus_wvalid = bvalid_q;
  assign bus_waddr  = beat_q.addr;
  assign bus_wdata  = beat_q.data;
  assign bus_wselct = beat_q.selct;
  assign gnt_vld    = owning_s;
  assign gnt_id     = own_q;

endmodule

// File: tb/tb_trigger_bus_arbiter.sv
// Directed bench for trigger_bus_arbiter: grant-selection vector table plus
// sequences for single beat, locked burst, backpressure, fairness and reset.
module tb_trigger_bus_arbiter;

  localparam int RN  = 4;
  localparam int BAW = 8;
  localparam int BDW = 32;
  localparam int BSW = 4;
  localparam int RIW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [RN-1:0]     req_wvalid = '0;
  logic [RN-1:0]     req_wready;
  logic [RN*BAW-1:0] req_waddr = '0;
  logic [RN*BDW-1:0] req_wdata = '0;
  logic [RN*BSW-1:0] req_wselct = '0;
  logic [RN-1:0]     req_wlock = '0;
  logic              bus_wvalid;
  logic              bus_wready = 1'b1;
  logic [BAW-1:0]    bus_waddr;
  logic [BDW-1:0]    bus_wdata;
  logic [BSW-1:0]    bus_wselct;
  logic              gnt_vld;
  logic [RIW-1:0]    gnt_id;

  trigger_bus_arbiter #(.BAW(BAW), .BDW(BDW), .BSW(BSW), .RN(RN)) dut (
    .clk(clk), .rst(rst),
    .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wselct(req_wselct),
    .req_wlock(req_wlock),
    .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
    .bus_waddr(bus_waddr), .bus_wdata(bus_wdata), .bus_wselct(bus_wselct),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BAW-1:0] addr;
    logic [BDW-1:0] data;
    logic [BSW-1:0] sel;
    logic           lock;
  } beat_t;

  typedef struct {
    logic [BAW-1:0] addr;
    logic [BDW-1:0] data;
    logic [BSW-1:0] sel;
    int             cyc;
  } obs_t;

  typedef struct {
    int            pre;
    logic [RN-1:0] valid;
    logic [RN-1:0] lock;
    logic          exp_vld;
    int            exp_id;
    logic [RN-1:0] exp_rdy;
  } vec_t;

  beat_t          txq[RN][$];
  obs_t           bus_log[$];
  int             gnt_log[$];
  vec_t           vecs[9];
  logic [RN-1:0]  hs;
  logic           gnt_prev, prev_stalled;
  logic [BAW+BDW+BSW-1:0] prev_out;
  int cyc, stall_st, stall_len, stall_viol, rdy_viol, stall_cyc;
  int checks = 0;
  int errors = 0;
  int bad, n, total, mx, mn;
  int cnt[RN];

  function automatic beat_t mk(input logic [BAW-1:0] a, input logic [BDW-1:0] d,
                               input logic [BSW-1:0] s, input logic l);
    beat_t b;
    b.addr = a; b.data = d; b.sel = s; b.lock = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive requester heads after the edge, observe at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < RN; i++) begin
      if (hs[i] && txq[i].size() > 0) void'(txq[i].pop_front());
    end
    bus_wready = !(cyc >= stall_st && cyc < stall_st + stall_len);
    for (int i = 0; i < RN; i++) begin
      if (txq[i].size() > 0) begin
        req_wvalid[i] = 1'b1;
        req_wlock[i]  = txq[i][0].lock;
        req_waddr[i*BAW +: BAW]  = txq[i][0].addr;
        req_wdata[i*BDW +: BDW]  = txq[i][0].data;
        req_wselct[i*BSW +: BSW] = txq[i][0].sel;
      end else begin
        req_wvalid[i] = 1'b0;
        req_wlock[i]  = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < RN; i++) hs[i] = req_wvalid[i] & req_wready[i];
    if (bus_wvalid && bus_wready) bus_log.push_back('{bus_waddr, bus_wdata, bus_wselct, cyc});
    if (gnt_vld && !gnt_prev) gnt_log.push_back(int'(gnt_id));
    gnt_prev = gnt_vld;
    if (prev_stalled && (!bus_wvalid || {bus_waddr, bus_wdata, bus_wselct} !== prev_out)) stall_viol++;
    if (bus_wvalid && !bus_wready) begin
      stall_cyc++;
      if (req_wready !== '0) rdy_viol++;
    end
    prev_stalled = bus_wvalid && !bus_wready;
    prev_out     = {bus_waddr, bus_wdata, bus_wselct};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_wvalid = '0; req_wlock = '0; req_waddr = '0; req_wdata = '0; req_wselct = '0;
    bus_wready = 1'b1;
    for (int i = 0; i < RN; i++) txq[i].delete();
    bus_log.delete();
    gnt_log.delete();
    hs = '0; gnt_prev = 1'b0; prev_stalled = 1'b0; prev_out = '0;
    cyc = 0; stall_st = 0; stall_len = 0; stall_viol = 0; rdy_viol = 0; stall_cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < RN; i++) if (txq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input int budget, input string name);
    int k;
    k = 0;
    while (!(all_empty() && !bus_wvalid && !gnt_vld) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle after %0d cycles", name, k);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pre  valid    lock     vld   id  rdy
    vecs[0] = '{-1, 4'b0001, 4'b0000, 1'b1, 0, 4'b0001};
    vecs[1] = '{-1, 4'b1010, 4'b0000, 1'b1, 1, 4'b0010};
    vecs[2] = '{-1, 4'b0000, 4'b1000, 1'b1, 3, 4'b1000};
    vecs[3] = '{ 0, 4'b0001, 4'b0000, 1'b1, 0, 4'b0001};
    vecs[4] = '{ 0, 4'b1111, 4'b0000, 1'b1, 1, 4'b0010};
    vecs[5] = '{ 2, 4'b0111, 4'b0000, 1'b1, 0, 4'b0001};
    vecs[6] = '{ 3, 4'b1100, 4'b0000, 1'b1, 2, 4'b0100};
    vecs[7] = '{ 1, 4'b0100, 4'b0010, 1'b1, 2, 4'b0100};
    vecs[8] = '{-1, 4'b0000, 4'b0000, 1'b0, 0, 4'b0000};

    rst = 1'b0;
    #3;
    check("reset_bus_wvalid", 64'(bus_wvalid), 64'(1'b0));
    check("reset_gnt_vld", 64'(gnt_vld), 64'(1'b0));
    check("reset_req_wready", 64'(req_wready), 64'(4'b0000));
    check("reset_bus_out", 64'({bus_waddr, bus_wselct, gnt_id}), 64'(14'h0));

    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (vecs[v].pre >= 0) begin
        txq[vecs[v].pre].push_back(mk(8'h10, 32'h0000_00A0, 4'b0001, 1'b0));
        run_idle(20, $sformatf("vec%0d_pre", v));
      end
      req_wvalid = vecs[v].valid;
      req_wlock  = vecs[v].lock;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_gnt_vld", v), 64'(gnt_vld), 64'(vecs[v].exp_vld));
      if (vecs[v].exp_vld) check($sformatf("vec%0d_gnt_id", v), 64'(gnt_id), 64'(vecs[v].exp_id));
      check($sformatf("vec%0d_req_wready", v), 64'(req_wready), 64'(vecs[v].exp_rdy));
    end

    // Single unlocked beat from requester 0.
    do_reset();
    txq[0].push_back(mk(8'h08, 32'h0000_004F, 4'b0001, 1'b0));
    step();
    check("single_no_grant_yet", 64'(gnt_vld), 64'(1'b0));
    step();
    check("single_gnt_vld", 64'(gnt_vld), 64'(1'b1));
    check("single_gnt_id", 64'(gnt_id), 64'(0));
    check("single_req_wready", 64'(req_wready), 64'(4'b0001));
    check("single_bus_idle", 64'(bus_wvalid), 64'(1'b0));
    step();
    check("single_bus_wvalid", 64'(bus_wvalid), 64'(1'b1));
    check("single_bus_beat", 64'({bus_waddr, bus_wdata, bus_wselct}), 64'({8'h08, 32'h0000_004F, 4'b0001}));
    check("single_released", 64'(gnt_vld), 64'(1'b0));
    step();
    check("single_drained", 64'(bus_wvalid), 64'(1'b0));
    check("single_count", 64'(bus_log.size()), 64'(1));

    // Locked 1024-beat burst from requester 1 while 0 and 2 wait.
    do_reset();
    for (int k = 0; k < 1024; k++)
      txq[1].push_back(mk(8'(k % 256), 32'h0100_0000 | 32'(k), 4'b0010, k != 1023));
    step();
    step();
    check("burst_owner", 64'(gnt_id), 64'(1));
    txq[2].push_back(mk(8'hA2, 32'h0200_0000, 4'b0100, 1'b0));
    txq[0].push_back(mk(8'hA0, 32'h0000_0000, 4'b0001, 1'b0));
    run_idle(1200, "burst_idle");
    check("burst_total", 64'(bus_log.size()), 64'(1026));
    if (bus_log.size() == 1026) begin
      bad = 0;
      for (int k = 0; k < 1024; k++)
        if (bus_log[k].addr !== 8'(k % 256) || bus_log[k].data !== (32'h0100_0000 | 32'(k)) ||
            bus_log[k].sel !== 4'b0010) bad++;
      check("burst_order", 64'(bad), 64'(0));
      check("burst_back_to_back", 64'(bus_log[1023].cyc - bus_log[0].cyc), 64'(1023));
      check("burst_next_req2", 64'(bus_log[1024].data), 64'(32'h0200_0000));
      check("burst_then_req0", 64'({bus_log[1025].addr, bus_log[1025].data}), 64'({8'hA0, 32'h0}));
    end
    check("burst_grant_count", 64'(gnt_log.size()), 64'(3));
    if (gnt_log.size() == 3)
      check("burst_grant_seq", 64'({gnt_log[0][3:0], gnt_log[1][3:0], gnt_log[2][3:0]}), 64'(12'h120));

    // Backpressure mid-burst: bus_wready low for 5 cycles.
    do_reset();
    stall_st = 8;
    stall_len = 5;
    for (int k = 0; k < 20; k++)
      txq[3].push_back(mk(8'h40 + 8'(k), 32'h0300_0000 | 32'(k), 4'b1000, k != 19));
    run_idle(100, "bp_idle");
    check("bp_total", 64'(bus_log.size()), 64'(20));
    bad = 0;
    for (int k = 0; k < bus_log.size(); k++)
      if (bus_log[k].data !== (32'h0300_0000 | 32'(k)) || bus_log[k].addr !== 8'h40 + 8'(k)) bad++;
    check("bp_order", 64'(bad), 64'(0));
    check("bp_stall_cycles", 64'(stall_cyc), 64'(5));
    check("bp_outputs_stable", 64'(stall_viol), 64'(0));
    check("bp_ready_low", 64'(rdy_viol), 64'(0));

    // Fairness: all requesters with continuous unlocked single beats.
    do_reset();
    for (int i = 0; i < RN; i++)
      for (int k = 0; k < 100; k++)
        txq[i].push_back(mk(8'(k), {8'(i), 24'(k)}, 4'b0001, 1'b0));
    repeat (400) step();
    bad = 0;
    for (int j = 0; j < gnt_log.size(); j++) if (gnt_log[j] != j % RN) bad++;
    check("fair_rotation", 64'(bad), 64'(0));
    for (int i = 0; i < RN; i++) cnt[i] = 0;
    for (int j = 0; j < bus_log.size(); j++)
      if (int'(bus_log[j].data[31:24]) < RN) cnt[int'(bus_log[j].data[31:24])]++;
    total = 0; mx = cnt[0]; mn = cnt[0];
    for (int i = 0; i < RN; i++) begin
      total += cnt[i];
      if (cnt[i] > mx) mx = cnt[i];
      if (cnt[i] < mn) mn = cnt[i];
    end
    check("fair_spread_le1", 64'(mx - mn <= 1), 64'(1'b1));
    check("fair_throughput", 64'(total >= 190), 64'(1'b1));

    // Reset while a beat is stalled on the bus and requester 2 holds the grant.
    do_reset();
    stall_st = 3;
    stall_len = 1000;
    txq[2].push_back(mk(8'h21, 32'h0200_0001, 4'b0100, 1'b0));
    txq[2].push_back(mk(8'h22, 32'h0200_0002, 4'b0100, 1'b1));
    txq[2].push_back(mk(8'h23, 32'h0200_0003, 4'b0100, 1'b1));
    n = 0;
    while (!(bus_wvalid && !bus_wready && gnt_vld && gnt_log.size() == 2) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL rst_setup: stalled owner never reached after %0d cycles", n);
    end
    #1 rst = 1'b0;
    #1;
    check("rst_bus_wvalid", 64'(bus_wvalid), 64'(1'b0));
    check("rst_gnt_vld", 64'(gnt_vld), 64'(1'b0));
    check("rst_req_wready", 64'(req_wready), 64'(4'b0000));
    check("rst_bus_out", 64'({bus_waddr, bus_wdata, bus_wselct, gnt_id}), 64'(0));
    for (int i = 0; i < RN; i++) txq[i].delete();
    req_wvalid = '0; req_wlock = '0;
    stall_len = 0;
    bus_wready = 1'b1;
    hs = '0; gnt_prev = 1'b0; gnt_log.delete(); bus_log.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    txq[1].push_back(mk(8'h31, 32'h0100_0031, 4'b0010, 1'b0));
    txq[3].push_back(mk(8'h33, 32'h0300_0033, 4'b1000, 1'b0));
    n = 0;
    while (gnt_log.size() == 0 && n < 10) begin
      step();
      n++;
    end
    check("rst_first_grant_seen", 64'(gnt_log.size() > 0), 64'(1'b1));
    if (gnt_log.size() > 0) check("rst_first_grant_id", 64'(gnt_log[0]), 64'(1));
    run_idle(20, "rst_idle");
    check("rst_no_stale_beat", 64'(bus_log.size()), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
